// File: rtl/pci_noc_bridge.sv
// pci_noc_bridge
//
// Bridges a PCIe-side streaming interface onto a 2D mesh NoC and back.
// Ingress words are wrapped into flits carrying a destination node and a
// sequence number, then injected through a single-entry output register.
// Returning flits land in a reorder buffer indexed by sequence number, and
// egress drains that buffer strictly in sequence order.
//
// Ports
//   clk, rstn                           clock, asynchronous active-low reset
//   i_valid, i_data, o_ready            PCIe ingress handshake
//   o_valid, o_data, i_ready            PCIe egress handshake
//   o_noc_valid, o_noc_data, i_noc_ready  NoC injection handshake
//   i_noc_valid, i_noc_data, o_noc_ready  NoC ejection handshake
//   o_err                               sticky duplicate-ejection flag
//
// Flit layout: {payload, seq, y, x} with x in the LSBs.
// X and Y are expected to be at least 2; ROB_DEPTH a power of two >= 2.

module pci_noc_bridge #(
    parameter int unsigned X           = 8,
    parameter int unsigned Y           = 8,
    parameter int unsigned pck_num     = 12,
    parameter int unsigned data_width  = 256,
    parameter int unsigned x_size      = $clog2(X),
    parameter int unsigned y_size      = $clog2(Y),
    parameter int unsigned total_width = x_size + y_size + pck_num + data_width,
    parameter int unsigned ROB_DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rstn,

    input  logic                   i_valid,
    input  logic [data_width-1:0]  i_data,
    output logic                   o_ready,

    output logic                   o_valid,
    output logic [data_width-1:0]  o_data,
    input  logic                   i_ready,

    output logic                   o_noc_valid,
    output logic [total_width-1:0] o_noc_data,
    input  logic                   i_noc_ready,

    input  logic                   i_noc_valid,
    input  logic [total_width-1:0] i_noc_data,
    output logic                   o_noc_ready,

    output logic                   o_err
);

    localparam int unsigned RobW   = $clog2(ROB_DEPTH);
    localparam int unsigned CntW   = $clog2(ROB_DEPTH + 1);
    localparam int unsigned SeqLsb = x_size + y_size;

    // Injection register
    logic                   inj_valid_q;
    logic [total_width-1:0] inj_data_q;

    // Flit tagging state
    logic [x_size-1:0]      dest_x_q, dest_x_d;
    logic [y_size-1:0]      dest_y_q, dest_y_d;
    logic [pck_num-1:0]     seq_q;
    logic [CntW-1:0]        outstanding_q;

    // Reorder buffer
    logic [ROB_DEPTH-1:0]   slot_valid_q, slot_valid_d;
    logic [data_width-1:0]  slot_data_q [ROB_DEPTH];
    logic [RobW-1:0]        head_q;
    logic                   err_q;

    logic                   accept;
    logic                   egress;
    logic [RobW-1:0]        ej_slot;
    logic                   ej_write;
    logic                   ej_dup;
    logic                   unused_noc_hdr;

    // Capping outstanding at ROB_DEPTH guarantees every returning flit has
    // a free slot, so ejection never needs backpressure.
    assign o_ready  = (!inj_valid_q || i_noc_ready) && (outstanding_q < CntW'(ROB_DEPTH));
    assign accept   = i_valid && o_ready;
    assign egress   = o_valid && i_ready;

    assign o_noc_valid = inj_valid_q;
    assign o_noc_data  = inj_data_q;
    assign o_noc_ready = 1'b1;

    assign ej_slot  = i_noc_data[SeqLsb +: RobW];
    assign ej_dup   = i_noc_valid && slot_valid_q[ej_slot];
    assign ej_write = i_noc_valid && !slot_valid_q[ej_slot];

    // Routing header and upper sequence bits are not needed on ejection.
    assign unused_noc_hdr = ^i_noc_data[SeqLsb+pck_num-1:0];

    assign o_valid = slot_valid_q[head_q];
    assign o_data  = slot_data_q[head_q];
    assign o_err   = err_q;

    // Destination walks linear index x+X*y, skipping node (0,0) on wrap.
    always_comb begin
        dest_x_d = dest_x_q;
        dest_y_d = dest_y_q;
        if (dest_x_q == x_size'(X - 1)) begin
            if (dest_y_q == y_size'(Y - 1)) begin
                dest_x_d = x_size'(1);
                dest_y_d = '0;
            end else begin
                dest_x_d = '0;
                dest_y_d = dest_y_q + y_size'(1);
            end
        end else begin
            dest_x_d = dest_x_q + x_size'(1);
        end
    end

    // An ejection can never hit the head slot being drained in the same
    // cycle: that slot is valid, so the flit is treated as a duplicate.
    always_comb begin
        slot_valid_d = slot_valid_q;
        if (egress) begin
            slot_valid_d[head_q] = 1'b0;
        end
        if (ej_write) begin
            slot_valid_d[ej_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inj_valid_q   <= 1'b0;
            inj_data_q    <= '0;
            dest_x_q      <= x_size'(1);
            dest_y_q      <= '0;
            seq_q         <= '0;
            outstanding_q <= '0;
            slot_valid_q  <= '0;
            head_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            if (accept) begin
                inj_valid_q <= 1'b1;
                inj_data_q  <= {i_data, seq_q, dest_y_q, dest_x_q};
                dest_x_q    <= dest_x_d;
                dest_y_q    <= dest_y_d;
                seq_q       <= seq_q + pck_num'(1);
            end else if (i_noc_ready) begin
                inj_valid_q <= 1'b0;
            end

            unique case ({accept, egress})
                2'b10:   outstanding_q <= outstanding_q + CntW'(1);
                2'b01:   outstanding_q <= outstanding_q - CntW'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            slot_valid_q <= slot_valid_d;
            if (egress) begin
                head_q <= head_q + RobW'(1);
            end
            if (ej_dup) begin
                err_q <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (ej_write) begin
            slot_data_q[ej_slot] <= i_noc_data[total_width-1 -: data_width];
        end
    end

endmodule

// File: tb/tb_pci_noc_bridge.sv
module tb_pci_noc_bridge;

    localparam int unsigned PX  = 2;
    localparam int unsigned PY  = 2;
    localparam int unsigned PN  = 12;
    localparam int unsigned DW  = 32;
    localparam int unsigned TW  = 1 + 1 + PN + DW;
    localparam int unsigned ROB = 8;

    logic          clk;
    logic          rstn;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic          o_noc_valid;
    logic [TW-1:0] o_noc_data;
    logic          i_noc_ready;
    logic          i_noc_valid;
    logic [TW-1:0] i_noc_data;
    logic          o_noc_ready;
    logic          o_err;

    pci_noc_bridge #(
        .X          (PX),
        .Y          (PY),
        .pck_num    (PN),
        .data_width (DW),
        .ROB_DEPTH  (ROB)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_ready     (i_ready),
        .o_noc_valid (o_noc_valid),
        .o_noc_data  (o_noc_data),
        .i_noc_ready (i_noc_ready),
        .i_noc_valid (i_noc_valid),
        .i_noc_data  (i_noc_data),
        .o_noc_ready (o_noc_ready),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboards: injected flits, egress payloads, and flits to loop back.
    logic [TW-1:0] noc_exp[$];
    logic [DW-1:0] eg_exp[$];
    logic [TW-1:0] sent[$];

    // Reference model of destination and sequence tagging.
    logic          m_x;
    logic          m_y;
    logic [PN-1:0] m_seq;

    typedef struct {
        logic [DW-1:0] data;
        logic          x;
        logic          y;
        logic [PN-1:0] seq;
    } vec_t;

    vec_t vecs[4];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rstn && o_noc_valid && i_noc_ready) begin
            if (noc_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL noc_unexpected: got %0h, required no flit", o_noc_data);
            end else begin
                check("noc_flit", o_noc_data, noc_exp.pop_front());
            end
        end
        if (rstn && o_valid && i_ready) begin
            if (eg_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL egress_unexpected: got %0h, required no word", o_data);
            end else begin
                check("egress_data", o_data, eg_exp.pop_front());
            end
        end
    end

    task automatic model_reset();
        m_x   = 1'b1;
        m_y   = 1'b0;
        m_seq = '0;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        logic [TW-1:0] f;
        f = {d, m_seq, m_y, m_x};
        check("o_ready_before_accept", o_ready, 1);
        i_valid = 1'b1;
        i_data  = d;
        noc_exp.push_back(f);
        eg_exp.push_back(d);
        sent.push_back(f);
        if (m_x) begin
            m_x = 1'b0;
            if (m_y) begin
                m_x = 1'b1;
                m_y = 1'b0;
            end else begin
                m_y = 1'b1;
            end
        end else begin
            m_x = 1'b1;
        end
        m_seq = m_seq + 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic noc_return(input logic [TW-1:0] f);
        i_noc_valid = 1'b1;
        i_noc_data  = f;
        @(posedge clk);
        #1;
        i_noc_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((eg_exp.size() != 0 || noc_exp.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (eg_exp.size() != 0 || noc_exp.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d words left, required 0", name,
                     eg_exp.size() + noc_exp.size());
        end
    endtask

    initial begin
        logic [TW-1:0] held;
        logic [TW-1:0] dup;

        vecs[0] = '{data: 32'hA000_0000, x: 1'b1, y: 1'b0, seq: 12'd0};
        vecs[1] = '{data: 32'hA000_0001, x: 1'b0, y: 1'b1, seq: 12'd1};
        vecs[2] = '{data: 32'hA000_0002, x: 1'b1, y: 1'b1, seq: 12'd2};
        vecs[3] = '{data: 32'hA000_0003, x: 1'b1, y: 1'b0, seq: 12'd3};

        rstn        = 1'b0;
        i_valid     = 1'b0;
        i_data      = '0;
        i_ready     = 1'b0;
        i_noc_ready = 1'b1;
        i_noc_valid = 1'b0;
        i_noc_data  = '0;
        model_reset();
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_noc_valid", o_noc_valid, 0);
        check("rst_o_err", o_err, 0);
        check("rst_o_ready", o_ready, 1);
        check("rst_o_noc_ready", o_noc_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Destination and sequence tagging, back to back.
        sent.delete();
        for (int i = 0; i < 4; i++) begin
            send_word(vecs[i].data);
            check("vec_noc_valid", o_noc_valid, 1);
            check("vec_x", o_noc_data[0], vecs[i].x);
            check("vec_y", o_noc_data[1], vecs[i].y);
            check("vec_seq", o_noc_data[2 +: PN], vecs[i].seq);
            check("vec_payload", o_noc_data[TW-1 -: DW], vecs[i].data);
        end
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) noc_return(sent[i]);
        wait_drain("drain_in_order");
        check("idle_o_valid", o_valid, 0);
        i_ready = 1'b0;

        // Fill the ROB, return in reverse, then release one slot.
        sent.delete();
        for (int i = 0; i < 8; i++) send_word(32'hB000_0000 + i);
        check("full_o_ready", o_ready, 0);
        i_valid = 1'b1;
        i_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        check("full_no_inject", o_noc_valid, 0);
        for (int i = 7; i >= 1; i--) begin
            noc_return(sent[i]);
            check("rob_hold_back", o_valid, 0);
        end
        noc_return(sent[0]);
        check("rob_head_valid", o_valid, 1);
        check("rob_head_data", o_data, 32'hB000_0000);
        check("full_before_egress", o_ready, 0);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check("ready_after_egress", o_ready, 1);
        i_ready = 1'b1;
        wait_drain("drain_reverse");
        i_ready = 1'b0;

        // Injection stall holds the flit stable.
        sent.delete();
        i_noc_ready = 1'b0;
        send_word(32'hC000_0000);
        held = sent[0];
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_data  = 32'hC000_0001;
            check("stall_o_ready", o_ready, 0);
            @(posedge clk);
            #1;
            check("stall_noc_valid", o_noc_valid, 1);
            check("stall_noc_data", o_noc_data, held);
        end
        i_valid     = 1'b0;
        i_noc_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_released", o_noc_valid, 0);
        noc_return(sent[0]);
        i_ready = 1'b1;
        wait_drain("drain_stall");
        i_ready = 1'b0;

        // Duplicate ejection.
        sent.delete();
        for (int i = 0; i < 4; i++) send_word(32'hD000_0000 + i);
        @(posedge clk);
        #1;
        noc_return(sent[1]);
        check("dup_err_before", o_err, 0);
        dup = sent[1];
        dup[TW-1 -: DW] = 32'hBAD0_0001;
        noc_return(dup);
        check("dup_err_set", o_err, 1);
        noc_return(sent[0]);
        noc_return(sent[2]);
        noc_return(sent[3]);
        i_ready = 1'b1;
        wait_drain("drain_dup");
        check("dup_err_sticky", o_err, 1);
        i_ready = 1'b0;

        // Reset mid-operation.
        sent.delete();
        for (int i = 0; i < 4; i++) send_word(32'hE000_0000 + i);
        noc_return(sent[0]);
        check("pre_reset_o_valid", o_valid, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_o_valid", o_valid, 0);
        check("mid_rst_o_err", o_err, 0);
        check("mid_rst_noc_valid", o_noc_valid, 0);
        noc_exp.delete();
        eg_exp.delete();
        sent.delete();
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("post_rst_o_ready", o_ready, 1);
        check("post_rst_o_noc_ready", o_noc_ready, 1);
        @(posedge clk);
        #1;
        check("post_rst_o_valid", o_valid, 0);
        send_word(32'h5A5A_0000);
        check("post_rst_seq", o_noc_data[2 +: PN], 0);
        check("post_rst_x", o_noc_data[0], 1);
        check("post_rst_y", o_noc_data[1], 0);
        noc_return(sent[0]);
        i_ready = 1'b1;
        wait_drain("drain_post_reset");
        i_ready = 1'b0;

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_noc_bridge.md
PCI_NOC_BRIDGE -- requirements
Module: pci_noc_bridge

Interface
REQ-001 SHALL have parameter X, default 8, meaning mesh columns.
REQ-002 SHALL have parameter Y, default 8, meaning mesh rows.
REQ-003 SHALL have parameter pck_num, default 12, meaning sequence-number field width.
REQ-004 SHALL have parameter data_width, default 256, meaning payload width.
REQ-005 SHALL have parameters x_size=$clog2(X) and y_size=$clog2(Y), meaning coordinate widths.
REQ-006 SHALL have parameter total_width=x_size+y_size+pck_num+data_width, meaning NoC flit width.
REQ-007 SHALL have parameter ROB_DEPTH, default 8, a power of two no greater than 2^pck_num, meaning the reorder-buffer depth.
REQ-008 SHALL have port clk, input, 1, the single clock.
REQ-009 SHALL have port rstn, input, 1, the asynchronous active-low reset.
REQ-010 SHALL have ports i_valid (input, 1), i_data (input, data_width) and o_ready (output, 1) forming the PCIe ingress handshake.
REQ-011 SHALL have ports o_valid (output, 1), o_data (output, data_width) and i_ready (input, 1) forming the PCIe egress handshake.
REQ-012 SHALL have ports o_noc_valid (output, 1), o_noc_data (output, total_width) and i_noc_ready (input, 1) forming the NoC injection handshake.
REQ-013 SHALL have ports i_noc_valid (input, 1), i_noc_data (input, total_width) and o_noc_ready (output, 1) forming the NoC ejection handshake.
REQ-014 SHALL have port o_err, output, 1, a sticky protocol-error flag.

Function
REQ-015 SHALL use this flit layout: x dest [x_size-1:0], y dest [x_size+:y_size], sequence [x_size+y_size+:pck_num], payload in the top data_width bits.
REQ-016 SHALL accept an ingress word only when i_valid and o_ready are both high in the same cycle.
REQ-017 SHALL drive o_ready = (injection register empty, or i_noc_ready high) AND outstanding < ROB_DEPTH.
REQ-018 SHALL load one flit into the injection register on acceptance and present it on o_noc_* in the next cycle (latency 1).
REQ-019 SHALL hold o_noc_valid and o_noc_data stable until the cycle in which i_noc_ready is high.
REQ-020 SHALL support back-to-back acceptance, one word per cycle, while i_noc_ready stays high.
REQ-021 SHALL keep a destination pointer holding linear index x+X*y: it starts at 1, increments once per accepted word, and wraps from X*Y-1 to 1, so node (0,0) is never targeted.
REQ-022 SHALL keep a pck_num-bit sequence counter that starts at 0, increments once per accepted word, and wraps modulo 2^pck_num.
REQ-023 SHALL keep an outstanding counter in the range 0..ROB_DEPTH: +1 on ingress acceptance, -1 on egress transfer, unchanged when both occur in the same cycle.
REQ-024 SHALL hold o_noc_ready at 1 constantly, since REQ-017 guarantees a free slot for every in-flight packet.
REQ-025 SHALL, on i_noc_valid, write the payload into reorder slot seq mod ROB_DEPTH and set that slot's valid bit.
REQ-026 SHALL, when an ejected flit targets a slot whose valid bit is already set, discard the flit, leave the slot unchanged, and set o_err until reset.
REQ-027 SHALL keep a log2(ROB_DEPTH)-bit head pointer that starts at 0.
REQ-028 SHALL drive o_valid = valid[head] and o_data = data[head].
REQ-029 SHALL, on each egress transfer (o_valid and i_ready), clear valid[head] and increment head with wrap.
REQ-030 SHALL emit egress words strictly in sequence order, regardless of NoC return order.
REQ-031 SHALL apply both operations when an ejection write and an egress transfer hit different slots in the same cycle.

Reset
REQ-032 SHALL, while rstn is low, asynchronously clear o_valid, o_noc_valid, o_err, the slot valid bits, head, the sequence counter and the outstanding counter, and set the destination pointer to 1.
REQ-033 SHALL, on reset asserted mid-operation, drop all in-flight and buffered data with no egress output, and drive o_ready=1 and o_noc_ready=1 on the first cycle after release.

Verification
REQ-034 SHALL cover: X=Y=2 with 3 words accepted and i_noc_ready=1 -> flits target (1,0),(0,1),(1,1) with seq 0,1,2; a 4th word targets (1,0) with seq 3.
REQ-035 SHALL cover: 8 words accepted, NoC returns seq 7..0 in reverse order -> egress emits payloads of seq 0..7 in order, with o_valid first high only after seq 0 arrives.
REQ-036 SHALL cover: 8 outstanding with no returns and ROB_DEPTH=8 -> o_ready=0; one egress transfer -> o_ready=1 in the following cycle.
REQ-037 SHALL cover: i_noc_ready held low for 5 cycles with a flit pending -> o_noc_data stays stable and o_ready=0 throughout.
REQ-038 SHALL cover: seq 3 ejected twice before drain -> o_err=1, first payload kept, egress order intact.
REQ-039 SHALL cover: rstn pulsed low with 4 packets outstanding -> o_valid=0 and o_err=0 immediately, and the next accepted word carries seq 0 to destination (1,0).
